ef_i2s_decim: RTL and testbench
===============================

// Module: ef_i2s_decim
// PURPOSE
//  Downstream consumer of the I2S receiver's sample FIFO. It pops samples from the FIFO
//  and averages blocks of 2^k samples (boxcar decimation). Each block produces one
//  averaged sample plus the block's peak magnitude on a valid/ready stream.
//  Sits between the I2S RX FIFO read port and the bus/DMA or DSP sink.
// PARAMETERS
//  DW        32  sample width of FIFO read data and of m_data
//  MAX_LOG2   5  largest supported log2 decimation ratio (block of 32 samples)
// PORTS
//  clk          in   1            system clock; the only clock
//  rst_n        in   1            asynchronous, active-low reset
//  en           in   1            block enable; low = flush and idle
//  sample_signed in  1            1: samples are two's complement; 0: unsigned
//  log2_ratio   in   3            block size N = 2^log2_ratio; values >MAX_LOG2 clamp to MAX_LOG2
//  fifo_empty   in   1            RX FIFO empty flag
//  fifo_rdata   in   DW           RX FIFO head word (show-ahead: valid whenever !fifo_empty)
//  fifo_rd      out  1            FIFO pop strobe (combinational)
//  m_valid      out  1            averaged sample available
//  m_ready      in   1            sink accepts when m_valid & m_ready
//  m_data       out  DW           block average (sum >> log2_ratio; arithmetic if signed)
//  m_peak       out  DW           max |sample| in block, unsigned
//  busy         out  1            state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, acc=0, cnt=0, peak=0, m_valid=0, m_data=0, m_peak=0; fifo_rd=0.
//  - FSM states: IDLE, ACC, OUT.
//    IDLE->ACC when en=1. ACC->OUT on the pop that completes N samples.
//    OUT->ACC on an m_valid&m_ready handshake. Any state->IDLE when en=0 (checked first).
//  - fifo_rd = (state==ACC) & en & ~fifo_empty. One pop per cycle max; back-to-back pops allowed.
//  - Data is consumed in the same cycle as fifo_rd. There are no pops in IDLE or OUT.
//  - log2_ratio is clamped and latched into ratio_q when a block starts (cnt==0 and first pop).
//    Changes mid-block are ignored until the next block.
//  - Accumulator: width DW+MAX_LOG2. The sample is sign-extended if sample_signed, else zero-extended.
//    The first pop of a block loads acc (it does not add). The counter cnt has MAX_LOG2+1 bits.
//  - Magnitude: signed negative x -> -x as unsigned DW; -2^(DW-1) -> 2^(DW-1) (no saturation).
//    peak = max(peak, |x|); the first pop of a block loads peak.
//  - The last pop (cnt==N-1) registers m_data = (acc_next >> ratio_q)[DW-1:0].
//    The shift is arithmetic when signed, i.e. rounds toward -inf. m_peak = peak_next.
//    m_valid=1 the next cycle, giving 1-cycle latency from the last pop.
//  - N=1 (log2_ratio=0): every pop goes straight to OUT, so m_data = sample and m_peak = |sample|.
//  - OUT: m_valid, m_data and m_peak are held stable until the handshake. Backpressure stalls pops.
//    The FIFO may fill; the upstream FIFO handles that as its own full case.
//  - On the handshake cycle: m_valid->0 next cycle, acc/cnt/peak cleared, state->ACC.
//    The next pop can happen in the cycle after the handshake. Max throughput: 1 output per N+1 cycles.
//  - en falling in any state: next cycle state=IDLE, m_valid=0, acc/cnt/peak cleared.
//    The partial block is discarded and fifo_rd drops the same cycle (combinational on en).
//    This is a deliberate flush and is exempt from stream stability rules.
//  - fifo_empty gaps mid-block: no pop, no count change, no timeout.
//  - Async reset mid-block: immediately returns to the reset values; there is no recovery of partial data.
// STRUCTURE
//  - Shared package ef_i2s_pkg holds the FSM state encoding (IDLE=2'd0, ACC=2'd1, OUT=2'd2)
//    and DEFAULT_MAX_LOG2=5. The RX FIFO data width constant also lives there.
//  - One sub-module, ef_i2s_abs #(DW): combinational |x| with a signed-mode select, instantiated once.
//  - Top level: FSM, counter, accumulator, peak register, output registers.
// TESTING
//  1. Unsigned, log2_ratio=2, pops 10,20,30,40 -> one beat m_data=25, m_peak=40; fifo_rd high exactly 4 cycles.
//  2. Signed, log2_ratio=2, pops -4,-4,-4,-3 -> m_data=32'hFFFFFFFC (-4, floor of -3.75), m_peak=4.
//  3. Signed, log2_ratio=0, pop 32'h80000000 -> m_data=32'h80000000, m_peak=32'h80000000, valid 1 cycle after pop.
//  4. m_ready held low 10 cycles with FIFO non-empty -> m_valid/m_data/m_peak stable, fifo_rd=0 throughout;
//     the first pop comes the cycle after the handshake.
//  5. en dropped after 2 of 4 pops, re-enabled, pops 1,1,1,1 -> no beat from the partial block; next beat m_data=1.
//  6. log2_ratio=7 (clamped to 5), 32 pops of value 3 with random fifo_empty gaps, ratio changed mid-block ->
//     exactly one beat, m_data=3, m_peak=3.

Source files
------------

// File: rtl/ef_i2s_pkg.sv
// Shared constants and FSM encoding for the I2S receive-side blocks.
package ef_i2s_pkg;

    // RX FIFO read-data width.
    localparam int RX_FIFO_DW       = 32;
    // Largest log2 block size the decimator supports.
    localparam int DEFAULT_MAX_LOG2 = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/ef_i2s_abs.sv
// Combinational magnitude of a sample. In signed mode a negative value is
// negated modulo 2^DW, so the most negative input maps to 2^(DW-1) unsigned.
module ef_i2s_abs #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] i_x,
    input  logic          i_signed,
    output logic [DW-1:0] o_abs
);

    logic w_neg;

    assign w_neg = i_signed && i_x[DW-1];
    assign o_abs = w_neg ? ({DW{1'b0}} - i_x) : i_x;

endmodule

// File: rtl/ef_i2s_decim.sv
// Boxcar decimator: pops 2^k samples from the RX FIFO, emits their floor
// average and peak magnitude on a valid/ready stream. en low flushes.
module ef_i2s_decim
    import ef_i2s_pkg::*;
#(
    parameter int DW       = RX_FIFO_DW,
    parameter int MAX_LOG2 = DEFAULT_MAX_LOG2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_sample_signed,
    input  logic [2:0]    i_log2_ratio,
    input  logic          i_fifo_empty,
    input  logic [DW-1:0] i_fifo_rdata,
    output logic          o_fifo_rd,
    output logic          o_m_valid,
    input  logic          i_m_ready,
    output logic [DW-1:0] o_m_data,
    output logic [DW-1:0] o_m_peak,
    output logic          o_busy
);

    localparam int         AW    = DW + MAX_LOG2;
    localparam int         CW    = MAX_LOG2 + 1;
    localparam logic [2:0] MAX_L = 3'(MAX_LOG2);

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_acc, w_acc_nxt, w_ext, w_shifted;
    logic [CW-1:0] r_cnt, w_last_idx;
    logic [DW-1:0] r_peak, w_peak_nxt, w_abs;
    logic [2:0]    r_ratio_q, w_ratio_clamp, w_ratio;
    logic          r_m_valid;
    logic [DW-1:0] r_m_data, r_m_peak;
    logic          w_pop, w_first, w_last, w_hs;

    // The ratio is sampled on the first pop of a block; afterwards the
    // latched copy governs both the block length and the final shift.
    assign w_ratio_clamp = (i_log2_ratio > MAX_L) ? MAX_L : i_log2_ratio;
    assign w_first       = (r_cnt == '0);
    assign w_ratio       = w_first ? w_ratio_clamp : r_ratio_q;
    assign w_last_idx    = (CW'(1) << w_ratio) - CW'(1);
    assign w_last        = (r_cnt == w_last_idx);

    assign w_pop = (r_state == ST_ACC) && i_en && !i_fifo_empty;
    assign w_hs  = r_m_valid && i_m_ready;

    assign w_ext = i_sample_signed ? {{MAX_LOG2{i_fifo_rdata[DW-1]}}, i_fifo_rdata}
                                   : {{MAX_LOG2{1'b0}}, i_fifo_rdata};
    assign w_acc_nxt  = w_first ? w_ext : (r_acc + w_ext);
    assign w_peak_nxt = (w_first || (w_abs > r_peak)) ? w_abs : r_peak;

    ef_i2s_abs #(.DW(DW)) u_abs (
        .i_x      (i_fifo_rdata),
        .i_signed (i_sample_signed),
        .o_abs    (w_abs)
    );

    // Divide by N: arithmetic shift in signed mode so the average floors.
    always_comb begin
        w_shifted = w_acc_nxt >> w_ratio;
        if (i_sample_signed)
            w_shifted = $signed(w_acc_nxt) >>> w_ratio;
    end

    // Next-state logic; en low overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_ACC;
                ST_ACC:  if (w_pop && w_last) w_state_nxt = ST_OUT;
                ST_OUT:  if (w_hs) w_state_nxt = ST_ACC;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Accumulator, counter, peak and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_peak    <= '0;
            r_ratio_q <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_peak  <= '0;
        end else if (!i_en) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_peak    <= '0;
            r_m_valid <= 1'b0;
        end else if (w_pop) begin
            r_acc  <= w_acc_nxt;
            r_peak <= w_peak_nxt;
            r_cnt  <= r_cnt + CW'(1);
            if (w_first)
                r_ratio_q <= w_ratio_clamp;
            if (w_last) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_shifted[DW-1:0];
                r_m_peak  <= w_peak_nxt;
            end
        end else if (w_hs) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_peak    <= '0;
            r_m_valid <= 1'b0;
        end
    end

    assign o_fifo_rd = w_pop;
    assign o_m_valid = r_m_valid;
    assign o_m_data  = r_m_data;
    assign o_m_peak  = r_m_peak;
    assign o_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ef_i2s_decim.sv
// Bench for ef_i2s_decim: a queue-backed show-ahead FIFO model, a random-ready
// sink, directed vectors, corner sequences and randomized blocks checked
// against an arithmetic model (sum, floor division, max of magnitudes).
module tb_ef_i2s_decim;

    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_en = 1'b0, i_sample_signed = 1'b0;
    logic [2:0]  i_log2_ratio = 3'd0;
    logic        i_fifo_empty = 1'b1;
    logic [31:0] i_fifo_rdata = 32'h0;
    logic        i_m_ready = 1'b0;
    logic        o_fifo_rd, o_m_valid, o_busy;
    logic [31:0] o_m_data, o_m_peak;

    ef_i2s_decim dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_sample_signed(i_sample_signed),
        .i_log2_ratio(i_log2_ratio), .i_fifo_empty(i_fifo_empty), .i_fifo_rdata(i_fifo_rdata),
        .o_fifo_rd(o_fifo_rd), .o_m_valid(o_m_valid), .i_m_ready(i_m_ready),
        .o_m_data(o_m_data), .o_m_peak(o_m_peak), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [31:0] d; logic [31:0] p; } beat_t;
    typedef struct { bit sgn; int lg; int n; logic [31:0] s[4]; logic [31:0] ed; logic [31:0] ep; } vec_t;

    logic [31:0] fq[$];
    logic [31:0] mq[$];
    beat_t       got[$];
    beat_t       expq[$];
    int gap_pct = 0, rdy_pct = 100;
    bit pend_pop = 0, prev_vld = 0;
    int cyc = 0, pops = 0, last_pop_cyc = 0, vld_rise_cyc = 0, hs_cyc = 0, pop_after_hs_cyc = -1;
    int total = 0, bad = 0;
    vec_t tv[7];

    // FIFO/sink environment: present inputs on the falling edge, then note
    // which pops and handshakes the next rising edge will perform.
    always @(negedge i_clk) begin
        cyc++;
        if (pend_pop && fq.size() > 0) void'(fq.pop_front());
        pend_pop     = 0;
        i_fifo_empty = (fq.size() == 0) || ($urandom_range(99) < gap_pct);
        i_fifo_rdata = (fq.size() > 0) ? fq[0] : 32'h0;
        i_m_ready    = ($urandom_range(99) < rdy_pct);
        #1;
        if (o_fifo_rd) begin
            pend_pop = 1; pops++; last_pop_cyc = cyc;
            if (pop_after_hs_cyc < 0) pop_after_hs_cyc = cyc;
        end
        if (o_m_valid && !prev_vld) vld_rise_cyc = cyc;
        prev_vld = o_m_valid;
        if (o_m_valid && i_m_ready && i_en && i_rst_n) begin
            got.push_back('{o_m_data, o_m_peak});
            hs_cyc = cyc; pop_after_hs_cyc = -1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
        end
    endtask

    task automatic wait_beats(input string nm, input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin @(negedge i_clk); k++; end
        if (got.size() < n) begin
            total++; bad++;
            $display("FAIL %s timeout beats=%0d expected=%0d", nm, got.size(), n);
        end
    endtask

    task automatic wait_pops(input string nm, input int p0, input int n, input int budget);
        int k = 0;
        while (pops - p0 < n && k < budget) begin @(negedge i_clk); k++; end
        if (pops - p0 < n) begin
            total++; bad++;
            $display("FAIL %s timeout pops=%0d expected=%0d", nm, pops - p0, n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((fq.size() != 0 || o_m_valid || pend_pop) && k < budget) begin @(negedge i_clk); k++; end
        if (fq.size() != 0 || o_m_valid) begin
            total++; bad++;
            $display("FAIL idle timeout fifo=%0d valid=%0b expected=0", fq.size(), o_m_valid);
        end
    endtask

    task automatic set_vec(input int i, input bit sgn, input int lg, input int n,
                           input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] s3, input logic [31:0] ed, input logic [31:0] ep);
        tv[i].sgn = sgn; tv[i].lg = lg; tv[i].n = n;
        tv[i].s[0] = s0; tv[i].s[1] = s1; tv[i].s[2] = s2; tv[i].s[3] = s3;
        tv[i].ed = ed; tv[i].ep = ep;
    endtask

    // Reference: exact sum, floor division by N, max of true magnitudes.
    function automatic beat_t model(input int off, input int n, input bit sgn);
        longint sum = 0, v, q, a, pk = 0;
        beat_t b;
        for (int j = 0; j < n; j++) begin
            v = sgn ? longint'($signed(mq[off+j])) : longint'(mq[off+j]);
            a = (v < 0) ? -v : v;
            sum += v;
            if (a > pk) pk = a;
        end
        q = sum / n;
        if (sum < 0 && q * n != sum) q = q - 1;
        b.d = q[31:0]; b.p = pk[31:0];
        return b;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, ok_st, rd_any, lg, k, n, nb;
        logic [31:0] x;
        beat_t b;

        set_vec(0, 0, 2, 4, 10, 20, 30, 40, 25, 40);
        set_vec(1, 1, 2, 4, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFC, 4);
        set_vec(2, 1, 0, 1, 32'h80000000, 0, 0, 0, 32'h80000000, 32'h80000000);
        set_vec(3, 0, 1, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        set_vec(4, 1, 1, 2, 5, 32'hFFFFFFF9, 0, 0, 32'hFFFFFFFF, 7);
        set_vec(5, 1, 2, 4, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
        set_vec(6, 0, 0, 1, 32'h80000000, 0, 0, 0, 32'h80000000, 32'h80000000);

        // Reset: outputs cleared and no pops even with enable and data present.
        i_en = 1; fq.push_back(32'h55);
        repeat (3) @(negedge i_clk);
        #2;
        chk("rst_valid", o_m_valid, 0);
        chk("rst_data", o_m_data, 0);
        chk("rst_peak", o_m_peak, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_fifo_rd", o_fifo_rd, 0);
        fq.delete(); i_en = 0;
        @(negedge i_clk); i_rst_n = 1;
        @(negedge i_clk); #2;
        chk("idle_busy", o_busy, 0);
        @(negedge i_clk); i_en = 1;
        repeat (2) @(negedge i_clk);
        #2;
        chk("en_busy", o_busy, 1);

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            @(negedge i_clk);
            i_sample_signed = tv[i].sgn; i_log2_ratio = 3'(tv[i].lg);
            got.delete(); p0 = pops;
            for (int j = 0; j < tv[i].n; j++) fq.push_back(tv[i].s[j]);
            wait_beats($sformatf("vec%0d", i), 1, 100);
            repeat (3) @(negedge i_clk);
            #2;
            chk($sformatf("vec%0d_beats", i), got.size(), 1);
            if (got.size() > 0) begin
                chk($sformatf("vec%0d_data", i), got[0].d, tv[i].ed);
                chk($sformatf("vec%0d_peak", i), got[0].p, tv[i].ep);
            end
            chk($sformatf("vec%0d_pops", i), pops - p0, tv[i].n);
            chk($sformatf("vec%0d_latency", i), vld_rise_cyc - last_pop_cyc, 1);
        end

        // Backpressure: output held, no pops, first pop right after handshake.
        @(negedge i_clk);
        rdy_pct = 0; i_sample_signed = 0; i_log2_ratio = 3'd1; got.delete();
        fq.push_back(6); fq.push_back(8); fq.push_back(100); fq.push_back(100);
        k = 0;
        while (!o_m_valid && k < 50) begin @(negedge i_clk); k++; end
        chk("bp_valid_seen", o_m_valid, 1);
        ok_st = 1; rd_any = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge i_clk); #2;
            if (!(o_m_valid === 1'b1 && o_m_data === 32'd7 && o_m_peak === 32'd8)) ok_st = 0;
            if (o_fifo_rd !== 1'b0) rd_any = 1;
        end
        chk("bp_stable", ok_st, 1);
        chk("bp_no_pop", rd_any, 0);
        chk("bp_fifo_kept", fq.size(), 2);
        rdy_pct = 100;
        wait_beats("bp_hs", 1, 20);
        @(negedge i_clk); #2;
        chk("bp_first_pop", pop_after_hs_cyc - hs_cyc, 1);
        wait_beats("bp_second", 2, 20);
        if (got.size() > 1) begin
            chk("bp_beat0", {got[0].d, got[0].p}, {32'd7, 32'd8});
            chk("bp_beat1", {got[1].d, got[1].p}, {32'd100, 32'd100});
        end
        wait_idle(50);

        // Flush: partial block discarded, fifo_rd gated by en.
        @(negedge i_clk);
        i_log2_ratio = 3'd2; got.delete(); p0 = pops;
        fq.push_back(9); fq.push_back(9);
        wait_pops("flush_pops", p0, 2, 20);
        @(negedge i_clk);
        i_en = 0; fq.push_back(5);
        repeat (3) @(negedge i_clk);
        #2;
        chk("flush_busy", o_busy, 0);
        chk("flush_valid", o_m_valid, 0);
        chk("flush_fifo_rd", o_fifo_rd, 0);
        chk("flush_fifo_kept", fq.size(), 1);
        fq.delete();
        @(negedge i_clk);
        i_en = 1;
        for (int j = 0; j < 4; j++) fq.push_back(1);
        wait_beats("flush_after", 1, 50);
        repeat (5) @(negedge i_clk);
        #2;
        chk("flush_beats", got.size(), 1);
        if (got.size() > 0) chk("flush_beat", {got[0].d, got[0].p}, {32'd1, 32'd1});

        // Clamp to 32 with gaps and random ready; mid-block ratio change ignored.
        @(negedge i_clk);
        i_log2_ratio = 3'd7; i_sample_signed = 1; gap_pct = 40; rdy_pct = 70;
        got.delete(); p0 = pops;
        for (int j = 0; j < 32; j++) fq.push_back(3);
        wait_pops("clamp_pops", p0, 5, 200);
        @(negedge i_clk); i_log2_ratio = 3'd1;
        wait_beats("clamp", 1, 2000);
        repeat (20) @(negedge i_clk);
        #2;
        chk("clamp_beats", got.size(), 1);
        if (got.size() > 0) chk("clamp_beat", {got[0].d, got[0].p}, {32'd3, 32'd3});
        chk("clamp_pops_total", pops - p0, 32);
        wait_idle(200);

        // Randomized blocks vs the arithmetic model.
        gap_pct = 30; rdy_pct = 60;
        for (int r = 0; r < 8; r++) begin
            wait_idle(500);
            @(negedge i_clk);
            lg = $urandom_range(7);
            i_log2_ratio = 3'(lg); i_sample_signed = 1'($urandom_range(1));
            k = (lg > 5) ? 5 : lg; n = 1 << k; nb = 2;
            mq.delete(); expq.delete(); got.delete();
            for (int j = 0; j < n * nb; j++) begin
                case ($urandom_range(3))
                    0: x = $urandom;
                    1: x = 32'($urandom_range(20)) - 32'd10;
                    2: x = $urandom_range(1) ? 32'h80000000 : 32'h7FFFFFFF;
                    default: x = $urandom;
                endcase
                mq.push_back(x); fq.push_back(x);
            end
            for (int bi = 0; bi < nb; bi++) expq.push_back(model(bi * n, n, i_sample_signed));
            wait_beats($sformatf("rnd%0d", r), nb, 3000);
            repeat (2) @(negedge i_clk);
            #2;
            chk($sformatf("rnd%0d_beats", r), got.size(), nb);
            for (int bi = 0; bi < nb; bi++) begin
                if (bi < got.size()) begin
                    b = expq[bi];
                    chk($sformatf("rnd%0d_b%0d_data", r, bi), got[bi].d, b.d);
                    chk($sformatf("rnd%0d_b%0d_peak", r, bi), got[bi].p, b.p);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
